// File: rtl/layer_two.sv
// Purpose : binary 3x3x8 XNOR-popcount convolution with per-filter threshold and 2x2 OR pooling,
//           producing an 8 x 7x7 map one output bit per cycle.
// Latency : one entry edge plus 392 write edges; done rises on the 393rd edge of an unpaused pass.
// Backpressure: none; dropping the phase input below 3'b011 freezes the pass, which resumes in place.
//
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-high reset
//   state          - top-level phase; 3'b011 enables this layer
//   layer_one_out  - 8ch x 14x14 binary input maps, bit ch*196 + r*14 + c
//   weights        - 8 filters x 3x3 x 8ch, bit f*72 + (kr*3+kc)*8 + ch
//   thresholds     - 7-bit unsigned threshold per filter at bits f*7 +: 7
//   layer_two_out  - 8 x 7x7 pooled map, bit f*49 + r*7 + c (registered)
//   done           - high once the full map of the current pass is written (registered)
module layer_two (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      state,
    input  logic [1567:0]   layer_one_out,
    input  logic [575:0]    weights,
    input  logic [55:0]     thresholds,
    output logic [391:0]    layer_two_out,
    output logic            done
);

    localparam logic [2:0] PHASE_L2 = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t           r_fsm;
    logic [2:0]     r_f;
    logic [2:0]     r_r;
    logic [2:0]     r_c;
    logic [391:0]   r_out;
    logic           r_done;

    logic           w_active;
    logic [5:0]     w_thr_base;
    logic [6:0]     w_thr;
    logic [8:0]     w_out_idx;
    logic           w_bit;
    logic [6:0]     w_cnt;
    logic           w_p;
    int             w_y;
    int             w_x;
    int             w_yy;
    int             w_xx;

    assign w_active   = (state == PHASE_L2);
    assign w_thr_base = {3'b000, r_f} * 6'd7;
    assign w_thr      = thresholds[w_thr_base +: 7];
    assign w_out_idx  = {6'b0, r_f} * 9'd49 + {6'b0, r_r} * 9'd7 + {6'b0, r_c};

    // The four conv windows feeding pooled cell (r_f, r_r, r_c) are evaluated in parallel;
    // any window reaching the threshold sets the pooled bit.
    always_comb begin
        w_bit = 1'b0;
        w_cnt = '0;
        w_p   = 1'b0;
        w_y   = 0;
        w_x   = 0;
        w_yy  = 0;
        w_xx  = 0;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                w_y   = 2 * int'(r_r) + dy;
                w_x   = 2 * int'(r_c) + dx;
                w_cnt = '0;
                for (int kr = 0; kr < 3; kr++) begin
                    for (int kc = 0; kc < 3; kc++) begin
                        for (int ch = 0; ch < 8; ch++) begin
                            w_yy = w_y + kr - 1;
                            w_xx = w_x + kc - 1;
                            // Padding samples read as 0 but still take part in the XNOR count.
                            if (w_yy >= 0 && w_yy < 14 && w_xx >= 0 && w_xx < 14) begin
                                w_p = layer_one_out[11'(ch * 196 + w_yy * 14 + w_xx)];
                            end else begin
                                w_p = 1'b0;
                            end
                            w_cnt = w_cnt + {6'b0,
                                ~(w_p ^ weights[10'(int'(r_f) * 72 + (kr * 3 + kc) * 8 + ch)])};
                        end
                    end
                end
                if (w_cnt >= w_thr) begin
                    w_bit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm  <= S_IDLE;
            r_f    <= '0;
            r_r    <= '0;
            r_c    <= '0;
            r_out  <= '0;
            r_done <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    r_f <= '0;
                    r_r <= '0;
                    r_c <= '0;
                    if (w_active) begin
                        r_fsm <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_active) begin
                        r_out[w_out_idx] <= w_bit;
                        if (r_c == 3'd6) begin
                            r_c <= '0;
                            if (r_r == 3'd6) begin
                                r_r <= '0;
                                if (r_f == 3'd7) begin
                                    r_f    <= '0;
                                    r_fsm  <= S_DONE;
                                    r_done <= 1'b1;
                                end else begin
                                    r_f <= r_f + 3'd1;
                                end
                            end else begin
                                r_r <= r_r + 3'd1;
                            end
                        end else begin
                            r_c <= r_c + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!w_active) begin
                        r_fsm  <= S_IDLE;
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign layer_two_out = r_out;
    assign done          = r_done;

endmodule
